// File: rtl/row_norm_issuer_pkg.sv
// Shared types for the row normalizer and the integer divider it feeds.
package row_norm_issuer_pkg;
   localparam int INT_W = 32;
   typedef logic signed [INT_W-1:0] INT_T;
   typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} norm_state_e;
endpackage

// File: rtl/row_norm_issuer.sv
// Streams one row of numerators through the shared divider against a common
// denominator, collects quotients in order and presents the normalized row.
module row_norm_issuer
   import row_norm_issuer_pkg::*;
#(
   parameter int VEC_LEN = 16,
   parameter int CNT_W   = $clog2(VEC_LEN) + 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     row_vld,
   output logic                     row_rdy,
   input  INT_T [VEC_LEN-1:0]       row_num,
   input  INT_T                     row_den,
   output logic                     div_req_vld,
   input  logic                     div_req_rdy,
   output INT_T                     div_num,
   output INT_T                     div_den,
   input  logic                     div_rsp_vld,
   output logic                     div_rsp_rdy,
   input  INT_T                     div_quot,
   output logic                     out_vld,
   input  logic                     out_rdy,
   output INT_T [VEC_LEN-1:0]       out_row,
   output logic                     out_dbz
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(VEC_LEN - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(VEC_LEN);

   norm_state_e         state;
   logic [CNT_W-1:0]    issue_idx;
   logic [CNT_W-1:0]    coll_idx;
   INT_T [VEC_LEN-1:0]  num_buf;
   INT_T                den_reg;

   assign div_num = num_buf[issue_idx[CNT_W-2:0]];
   assign div_den = den_reg;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         issue_idx   <= '0;
         coll_idx    <= '0;
         row_rdy     <= 1'b1;
         div_req_vld <= 1'b0;
         div_rsp_rdy <= 1'b0;
         out_vld     <= 1'b0;
         out_dbz     <= 1'b0;
         num_buf     <= '0;
         den_reg     <= '0;
         out_row     <= '0;
      end else begin
         // Capture runs alongside issue; responses come back in request order.
         if (div_rsp_vld && div_rsp_rdy) begin
            out_row[coll_idx[CNT_W-2:0]] <= div_quot;
            coll_idx                     <= coll_idx + 1'b1;
         end
         case (state)
            IDLE: begin
               if (row_vld && row_rdy) begin
                  num_buf     <= row_num;
                  den_reg     <= row_den;
                  out_dbz     <= (row_den == '0);
                  issue_idx   <= '0;
                  coll_idx    <= '0;
                  row_rdy     <= 1'b0;
                  div_req_vld <= 1'b1;
                  div_rsp_rdy <= 1'b1;
                  state       <= ISSUE;
               end
            end
            ISSUE: begin
               if (div_req_vld && div_req_rdy) begin
                  issue_idx <= issue_idx + 1'b1;
                  if (issue_idx == LAST_IDX) begin
                     div_req_vld <= 1'b0;
                     state       <= DRAIN;
                  end
               end
            end
            DRAIN: begin
               if (coll_idx == FULL_CNT) begin
                  div_rsp_rdy <= 1'b0;
                  out_vld     <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (out_rdy) begin
                  out_vld <= 1'b0;
                  row_rdy <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Collection can never overtake issue, and the divider must stay quiet when not asked.
   a_coll_in_issue: assert property (@(posedge clk) disable iff (rst)
      (state == ISSUE) |-> (coll_idx != FULL_CNT));
   a_stray_rsp: assert property (@(posedge clk) disable iff (rst)
      !(div_rsp_vld && !div_rsp_rdy));

endmodule

// File: tb/tb_row_norm_issuer.sv
// Row normalizer with a behavioural one-cycle divider; random and directed rows
// checked against plain integer division.
module tb_row_norm_issuer;
   import row_norm_issuer_pkg::*;

   localparam int VEC_LEN = 4;
   localparam int CNT_W   = $clog2(VEC_LEN) + 1;

   logic               clk = 1'b0;
   logic               rst;
   logic               row_vld;
   logic               row_rdy;
   INT_T [VEC_LEN-1:0] row_num;
   INT_T               row_den;
   logic               div_req_vld;
   logic               div_req_rdy;
   INT_T               div_num;
   INT_T               div_den;
   logic               div_rsp_vld;
   logic               div_rsp_rdy;
   INT_T               div_quot;
   logic               out_vld;
   logic               out_rdy;
   INT_T [VEC_LEN-1:0] out_row;
   logic               out_dbz;

   row_norm_issuer #(.VEC_LEN(VEC_LEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .row_vld(row_vld), .row_rdy(row_rdy),
      .row_num(row_num), .row_den(row_den),
      .div_req_vld(div_req_vld), .div_req_rdy(div_req_rdy),
      .div_num(div_num), .div_den(div_den),
      .div_rsp_vld(div_rsp_vld), .div_rsp_rdy(div_rsp_rdy), .div_quot(div_quot),
      .out_vld(out_vld), .out_rdy(out_rdy), .out_row(out_row), .out_dbz(out_dbz)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;
   int cyc   = 0;
   int stall_mode = 0;
   int phase = 0;
   int cur_num [VEC_LEN];
   int cur_den;
   int nxt_num [VEC_LEN];
   int nxt_den;
   int req_q [$];
   int hs_cyc;
   bit stalled_q = 1'b0;
   INT_T held_num, held_den;

   task automatic chk(input string tag, input longint act, input longint exp);
      n_chk++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d", tag, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // Divider stand-in: one-cycle latency, divide-by-zero returns 0.
   always @(posedge clk) begin
      if (rst) begin
         div_rsp_vld <= 1'b0;
         div_quot    <= '0;
      end else begin
         div_rsp_vld <= div_req_vld && div_req_rdy;
         if (div_req_vld && div_req_rdy)
            div_quot <= (div_den == '0) ? INT_T'(0) : INT_T'(div_num / div_den);
      end
   end

   always @(negedge clk) begin
      phase++;
      case (stall_mode)
         0:       div_req_rdy = 1'b1;
         1:       div_req_rdy = ((phase % 4) == 0) || ((phase % 4) == 3);
         default: div_req_rdy = 1'($urandom_range(0, 1));
      endcase
   end

   always @(posedge clk) begin
      if (!rst && stalled_q && div_req_vld) begin
         chk("req_hold_num", div_num, held_num);
         chk("req_hold_den", div_den, held_den);
      end
      if (!rst && div_req_vld && div_req_rdy) req_q.push_back(int'(div_num));
      stalled_q = !rst && div_req_vld && !div_req_rdy;
      held_num  = div_num;
      held_den  = div_den;
   end

   function automatic int ref_quot(input int n, input int d);
      return (d == 0) ? 0 : n / d;
   endfunction

   // Caller is at a negedge. keep holds row_vld high past the handshake with nxt_* data.
   task automatic do_row(input int hold, input bit keep, input bit chk_lat, input bit chk_b2b);
      bit ok;
      int acc;
      logic [VEC_LEN*INT_W-1:0] snap;
      req_q.delete();
      for (int i = 0; i < VEC_LEN; i++) row_num[i] = INT_T'(cur_num[i]);
      row_den = INT_T'(cur_den);
      row_vld = 1'b1;
      out_rdy = 1'b0;
      ok = 1'b0;
      for (int t = 0; t < 100; t++) begin
         if (row_rdy) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("accept_wait", ok, 1);
      @(negedge clk);
      acc = cyc;
      if (chk_b2b) chk("b2b_gap", acc - hs_cyc, 1);
      chk("busy_row_rdy", row_rdy, 0);
      if (keep) begin
         for (int i = 0; i < VEC_LEN; i++) row_num[i] = INT_T'(nxt_num[i]);
         row_den = INT_T'(nxt_den);
      end else row_vld = 1'b0;
      ok = 1'b0;
      for (int t = 0; t < 300; t++) begin
         if (out_vld) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("out_wait", ok, 1);
      if (chk_lat) chk("latency", cyc - acc, VEC_LEN + 2);
      for (int i = 0; i < VEC_LEN; i++)
         chk($sformatf("out_row[%0d]", i), out_row[i], ref_quot(cur_num[i], cur_den));
      chk("out_dbz", out_dbz, (cur_den == 0));
      chk("req_count", req_q.size(), VEC_LEN);
      for (int i = 0; i < VEC_LEN && i < req_q.size(); i++)
         chk($sformatf("req_order[%0d]", i), req_q[i], cur_num[i]);
      snap = out_row;
      for (int h = 0; h < hold; h++) begin
         row_vld = keep | h[0];
         @(negedge clk);
         chk("hold_vld", out_vld, 1);
         chk("hold_row", (out_row == snap), 1);
         chk("hold_row_rdy", row_rdy, 0);
      end
      row_vld = keep;
      out_rdy = 1'b1;
      @(negedge clk);
      hs_cyc = cyc;
      out_rdy = 1'b0;
      chk("post_out_vld", out_vld, 0);
      chk("post_row_rdy", row_rdy, 1);
   endtask

   initial begin
      bit ok;
      rst = 1'b1; row_vld = 1'b0; out_rdy = 1'b0; row_num = '0; row_den = '0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_row_rdy", row_rdy, 1);
      chk("rst_req_vld", div_req_vld, 0);
      chk("rst_rsp_rdy", div_rsp_rdy, 0);
      chk("rst_out_vld", out_vld, 0);
      chk("rst_out_dbz", out_dbz, 0);
      chk("rst_out_row", (out_row == '0), 1);

      // Basic row and latency
      stall_mode = 0;
      cur_num = '{100, -50, 7, 0}; cur_den = 5;
      do_row(0, 1'b0, 1'b1, 1'b0);

      // Divide by zero
      cur_num = '{9, 9, 9, 9}; cur_den = 0;
      do_row(0, 1'b0, 1'b1, 1'b0);

      // Request backpressure, same data as basic row
      stall_mode = 1;
      cur_num = '{100, -50, 7, 0}; cur_den = 5;
      do_row(0, 1'b0, 1'b0, 1'b0);

      // Output backpressure with ignored row_vld pulses
      stall_mode = 0;
      cur_num = '{-33, 64, 1000, -7}; cur_den = -3;
      do_row(10, 1'b0, 1'b1, 1'b0);

      // Reset mid-row after two requests issued
      cur_num = '{11, 22, 33, 44}; cur_den = 11;
      req_q.delete();
      for (int i = 0; i < VEC_LEN; i++) row_num[i] = INT_T'(cur_num[i]);
      row_den = INT_T'(cur_den);
      row_vld = 1'b1;
      @(negedge clk);
      row_vld = 1'b0;
      ok = 1'b0;
      for (int t = 0; t < 50; t++) begin
         if (req_q.size() >= 2) begin ok = 1'b1; break; end
         @(negedge clk);
      end
      chk("mid_wait", ok, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_row_rdy", row_rdy, 1);
      chk("mid_rst_out_vld", out_vld, 0);
      chk("mid_rst_req_vld", div_req_vld, 0);
      chk("mid_rst_out_row", (out_row == '0), 1);
      cur_num = '{8, 16, 24, 32}; cur_den = 8;
      do_row(0, 1'b0, 1'b1, 1'b0);

      // Back-to-back with row_vld held high
      cur_num = '{-90, 45, 3, 12}; cur_den = 9;
      nxt_num = '{77, -77, 5, 6}; nxt_den = 7;
      do_row(0, 1'b1, 1'b1, 1'b0);
      cur_num = nxt_num; cur_den = nxt_den;
      do_row(0, 1'b0, 1'b1, 1'b1);

      // Randomized rows under random request stalls
      stall_mode = 2;
      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < VEC_LEN; i++) cur_num[i] = int'($urandom_range(0, 2000)) - 1000;
         cur_den = int'($urandom_range(0, 40)) - 20;
         do_row(int'($urandom_range(0, 3)), 1'b0, 1'b0, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

endmodule
